// File: rtl/memory_arb2.sv
// memory_arb2: one block-RAM array shared by two requester ports (A, B) with
// byte-enable writes, a per-request req/gnt handshake and read-data valid strobes.
// Latency: read data and rvalid appear READ_LATENCY (1 or 2) cycles after acceptance.
// Backpressure: gnt is combinational; a losing port holds its request until granted.
//
// Ports (per requester X in {a, b}):
//   X_req/X_we/X_addr/X_data/X_be : request, write(1)/read(0), word address,
//                                   write data, byte enables (bit i -> data[8i+7:8i])
//   X_gnt                         : combinational grant; accept = req & gnt at clk edge
//   X_rvalid/X_rdata              : one-cycle read-return strobe; rdata holds otherwise
//   clk, rst                      : single clock, synchronous active-high reset
// Optional feature macro: MEMORY_ARB2_ROUND_ROBIN_EN
//   defined   -> round-robin on ties (last-winner register, A preferred after reset)
//   undefined -> fixed priority, A always wins a tie

module memory_arb2 #(
  parameter     FILE_NAME    = "mem_init.mif",
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [BE_WIDTH-1:0]   a_be,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic [BE_WIDTH-1:0]   b_be,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  (* ram_init_file = FILE_NAME *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_a_gnt;
  logic w_b_gnt;

`ifdef MEMORY_ARB2_ROUND_ROBIN_EN
  // r_prefer_b=1 means A won the last grant, so B takes the next tie.
  logic r_prefer_b;

  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!rst) begin
      if (a_req && b_req) begin
        w_a_gnt = !r_prefer_b;
        w_b_gnt = r_prefer_b;
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prefer_b <= 1'b0;
    end else if (w_a_gnt) begin
      r_prefer_b <= 1'b1;
    end else if (w_b_gnt) begin
      r_prefer_b <= 1'b0;
    end
  end
`else
  always_comb begin
    w_a_gnt = !rst && a_req;
    w_b_gnt = !rst && b_req && !a_req;
  end
`endif

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // Single array access path, steered by whichever port holds the grant.
  logic                  w_acc;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_WIDTH-1:0]   w_be;
  logic                  w_rd_a;
  logic                  w_rd_b;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_acc     = w_a_gnt || w_b_gnt;
  assign w_we      = w_b_gnt ? b_we   : a_we;
  assign w_addr    = w_b_gnt ? b_addr : a_addr;
  assign w_wdata   = w_b_gnt ? b_data : a_data;
  assign w_be      = w_b_gnt ? b_be   : a_be;
  assign w_rd_a    = w_a_gnt && !a_we;
  assign w_rd_b    = w_b_gnt && !b_we;
  assign w_rd_word = r_mem[w_addr];

  // Array is deliberately not reset; gnt already excludes writes during rst.
  always_ff @(posedge clk) begin
    if (w_acc && w_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (w_be[i]) begin
          r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // Source feeding the per-port output registers: either the array word at
  // acceptance (latency 1) or one extra shared pipeline stage (latency 2).
  logic                  w_src_vld_a;
  logic                  w_src_vld_b;
  logic [DATA_WIDTH-1:0] w_src_dat;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_s1_vld_a;
    logic                  r_s1_vld_b;
    logic [DATA_WIDTH-1:0] r_s1_dat;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1_vld_a <= 1'b0;
        r_s1_vld_b <= 1'b0;
        r_s1_dat   <= '0;
      end else begin
        r_s1_vld_a <= w_rd_a;
        r_s1_vld_b <= w_rd_b;
        if (w_rd_a || w_rd_b) begin
          r_s1_dat <= w_rd_word;
        end
      end
    end

    assign w_src_vld_a = r_s1_vld_a;
    assign w_src_vld_b = r_s1_vld_b;
    assign w_src_dat   = r_s1_dat;
  end else begin : g_lat1
    assign w_src_vld_a = w_rd_a;
    assign w_src_vld_b = w_rd_b;
    assign w_src_dat   = w_rd_word;
  end

  logic                  r_a_rvalid;
  logic                  r_b_rvalid;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;

  // rdata only loads on its own port's return, so it holds between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_src_vld_a;
      r_b_rvalid <= w_src_vld_b;
      if (w_src_vld_a) begin
        r_a_rdata <= w_src_dat;
      end
      if (w_src_vld_b) begin
        r_b_rdata <= w_src_dat;
      end
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_memory_arb2.sv
module tb_memory_arb2;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int NV = 14;

`ifdef MEMORY_ARB2_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic [BW-1:0] a_be, b_be;

  // latency-1 instance
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  // latency-2 instance (same stimulus)
  logic          a_gnt2, a_rvalid2, b_gnt2, b_rvalid2;
  logic [DW-1:0] a_rdata2, b_rdata2;

  int n_tests = 0;
  int n_fail  = 0;

  memory_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_be(a_be),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .b_be(b_be),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  memory_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data), .a_be(a_be),
    .a_gnt(a_gnt2), .a_rvalid(a_rvalid2), .a_rdata(a_rdata2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data), .b_be(b_be),
    .b_gnt(b_gnt2), .b_rvalid(b_rvalid2), .b_rdata(b_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ar, aw;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic [BW-1:0] abe;
    logic          br, bw;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic [BW-1:0] bbe;
    logic          eg_a, eg_b;
    logic          erv_a;
    logic [DW-1:0] erd_a;
    logic          erv_b;
    logic [DW-1:0] erd_b;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] dat, input logic [BW-1:0] be);
    a_req = req; a_we = we; a_addr = addr; a_data = dat; a_be = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] dat, input logic [BW-1:0] be);
    b_req = req; b_we = we; b_addr = addr; b_data = dat; b_be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a;

    // ar aw  aa     ad         abe    br   bw   ba     bd     bbe    gA   gB   rvA  rdA        rvB  rdB
    tbl[0]  = '{1'b1,1'b1,6'h00,16'h1234,2'b11, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[1]  = '{1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b1,6'h3F,16'hFFFF,2'b11, 1'b0,1'b1, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[2]  = '{1'b1,1'b1,6'h05,16'h1234,2'b11, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b0,16'h0000, 1'b0,16'h0000};
    tbl[3]  = '{1'b1,1'b0,6'h00,16'h0000,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b1,16'h1234, 1'b0,16'h0000};
    tbl[4]  = '{1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b0,1'b0, 1'b0,16'h1234, 1'b0,16'h0000};
    tbl[5]  = '{1'b1,1'b1,6'h05,16'hABCD,2'b01, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b0,16'h1234, 1'b0,16'h0000};
    tbl[6]  = '{1'b1,1'b0,6'h05,16'h0000,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b1,16'h12CD, 1'b0,16'h0000};
    tbl[7]  = '{1'b1,1'b1,6'h05,16'h5600,2'b10, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b0,16'h12CD, 1'b0,16'h0000};
    tbl[8]  = '{1'b1,1'b0,6'h05,16'h0000,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b1,16'h56CD, 1'b0,16'h0000};
    tbl[9]  = '{1'b1,1'b1,6'h05,16'hFFFF,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b0,16'h56CD, 1'b0,16'h0000};
    tbl[10] = '{1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0,6'h05,16'h0000,2'b00, 1'b0,1'b1, 1'b0,16'h56CD, 1'b1,16'h56CD};
    tbl[11] = '{1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0,6'h3F,16'h0000,2'b00, 1'b0,1'b1, 1'b0,16'h56CD, 1'b1,16'hFFFF};
    tbl[12] = '{1'b1,1'b0,6'h3F,16'h0000,2'b00, 1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0, 1'b1,16'hFFFF, 1'b0,16'hFFFF};
    tbl[13] = '{1'b0,1'b0,6'h00,16'h0000,2'b00, 1'b1,1'b0,6'h00,16'h0000,2'b00, 1'b0,1'b1, 1'b0,16'hFFFF, 1'b1,16'h1234};

    // Reset with both ports requesting: no grants, outputs cleared.
    rst = 1'b1;
    set_a(1'b1, 1'b0, 6'h00, '0, '0);
    set_b(1'b1, 1'b0, 6'h00, '0, '0);
    tick();
    tick();
    chk1("rst a_gnt", a_gnt, 1'b0);
    chk1("rst b_gnt", b_gnt, 1'b0);
    chk1("rst a_rvalid", a_rvalid, 1'b0);
    chk1("rst b_rvalid", b_rvalid, 1'b0);
    chk16("rst a_rdata", a_rdata, 16'h0000);
    chk16("rst b_rdata", b_rdata, 16'h0000);
    chk1("rst a_rvalid2", a_rvalid2, 1'b0);
    chk16("rst b_rdata2", b_rdata2, 16'h0000);
    rst = 1'b0;
    idle();

    // Table: preload, byte writes, reads on both ports (latency-1 instance).
    for (int i = 0; i < NV; i++) begin
      set_a(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].abe);
      set_b(tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd, tbl[i].bbe);
      #1;
      chk1($sformatf("v%0d a_gnt", i), a_gnt, tbl[i].eg_a);
      chk1($sformatf("v%0d b_gnt", i), b_gnt, tbl[i].eg_b);
      tick();
      chk1($sformatf("v%0d a_rvalid", i), a_rvalid, tbl[i].erv_a);
      chk16($sformatf("v%0d a_rdata", i), a_rdata, tbl[i].erd_a);
      chk1($sformatf("v%0d b_rvalid", i), b_rvalid, tbl[i].erv_b);
      chk16($sformatf("v%0d b_rdata", i), b_rdata, tbl[i].erd_b);
    end
    idle();
    tick();
    tick();

    // Latency 2: B reads 0x3F then 0x00 back to back.
    set_b(1'b1, 1'b0, 6'h3F, '0, '0);
    tick();
    chk1("l2 c1 b_rvalid2", b_rvalid2, 1'b0);
    chk1("l1 c1 b_rvalid", b_rvalid, 1'b1);
    chk16("l1 c1 b_rdata", b_rdata, 16'hFFFF);
    set_b(1'b1, 1'b0, 6'h00, '0, '0);
    tick();
    chk1("l2 c2 b_rvalid2", b_rvalid2, 1'b1);
    chk16("l2 c2 b_rdata2", b_rdata2, 16'hFFFF);
    chk16("l1 c2 b_rdata", b_rdata, 16'h1234);
    idle();
    tick();
    chk1("l2 c3 b_rvalid2", b_rvalid2, 1'b1);
    chk16("l2 c3 b_rdata2", b_rdata2, 16'h1234);
    chk1("l1 c3 b_rvalid", b_rvalid, 1'b0);
    tick();
    chk1("l2 c4 b_rvalid2", b_rvalid2, 1'b0);
    chk16("l2 c4 b_rdata2 hold", b_rdata2, 16'h1234);
    chk1("l2 c4 a_rvalid2", a_rvalid2, 1'b0);

    // Contention: arbitration state back to A preferred, then both request.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_a(1'b1, 1'b0, 6'h00, '0, '0);
      set_b(1'b1, 1'b0, 6'h3F, '0, '0);
      exp_a = RR ? ((c % 2) == 0) : 1'b1;
      #1;
      chk1($sformatf("cont%0d a_gnt", c), a_gnt, exp_a);
      chk1($sformatf("cont%0d b_gnt", c), b_gnt, !exp_a);
      tick();
      chk1($sformatf("cont%0d a_rvalid", c), a_rvalid, exp_a);
      chk1($sformatf("cont%0d b_rvalid", c), b_rvalid, !exp_a);
      if (exp_a) chk16($sformatf("cont%0d a_rdata", c), a_rdata, 16'h1234);
      else       chk16($sformatf("cont%0d b_rdata", c), b_rdata, 16'hFFFF);
    end
    set_a(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk1("cont drop b_gnt", b_gnt, 1'b1);
    chk1("cont drop a_gnt", a_gnt, 1'b0);
    tick();
    chk1("cont drop b_rvalid", b_rvalid, 1'b1);
    chk16("cont drop b_rdata", b_rdata, 16'hFFFF);
    idle();
    tick();
    tick();
    chk16("pre mid a_rdata2", a_rdata2, 16'h1234);

    // Reset mid-read on the latency-2 instance; write attempted during reset.
    set_a(1'b1, 1'b0, 6'h00, '0, '0);
    tick();
    rst = 1'b1;
    set_a(1'b1, 1'b1, 6'h05, 16'hFFFF, 2'b11);
    set_b(1'b1, 1'b0, 6'h00, '0, '0);
    #1;
    chk1("mid a_gnt", a_gnt, 1'b0);
    chk1("mid b_gnt", b_gnt, 1'b0);
    chk1("mid a_rvalid2 pre", a_rvalid2, 1'b0);
    tick();
    chk1("mid a_rvalid2", a_rvalid2, 1'b0);
    chk16("mid a_rdata2", a_rdata2, 16'h0000);
    chk16("mid a_rdata", a_rdata, 16'h0000);
    rst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("mid post%0d a_rvalid2", k), a_rvalid2, 1'b0);
    end
    set_a(1'b1, 1'b0, 6'h05, '0, '0);
    tick();
    chk1("post a_rvalid", a_rvalid, 1'b1);
    chk16("post a_rdata", a_rdata, 16'h56CD);
    idle();
    tick();
    chk1("post a_rvalid2", a_rvalid2, 1'b1);
    chk16("post a_rdata2", a_rdata2, 16'h56CD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arb2.md
Name: memory_arb2

Overview:
- Parameterised successor to the single-port synchronous RAM: one inferred block-RAM array shared by two independent requester ports (A, B).
- Adds a per-request handshake, byte-enable writes, a configurable read latency (1 or 2 cycles) and returned-data valid strobes.
- Sits between two bus masters (e.g. CPU data path and DMA/debug loader) and the on-chip memory.
- Contents are preloaded from an init file at configuration.

Parameters:
- FILE_NAME, "mem_init.mif", RAM init file attached to the array via ram_init_file.
- ADDR_WIDTH, 6, word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).
- READ_LATENCY, 1, cycles from accepted read to rvalid; legal values 1 or 2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- a_req  in  1  port A request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_WIDTH  port A word address
- a_data  in  DATA_WIDTH  port A write data
- a_be  in  BE_WIDTH  port A byte enables; bit i covers data[8i+7:8i]
- a_gnt  out  1  port A grant (combinational)
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DATA_WIDTH  port A read data
- b_req, b_we, b_addr, b_data, b_be, b_gnt, b_rvalid, b_rdata: same as port A, for port B

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- One array access per cycle.
  - A request is accepted in a cycle where req=1 and gnt=1 at the rising edge.
  - Requester holds req/we/addr/data/be stable until accepted.
- Grant is combinational from req and arbitration state.
  - Only one request pending: it is granted.
  - Both pending: arbitration policy decides (see Optional Feature).
  - gnt=0 whenever req=0.
- Accepted write: bytes with be[i]=1 updated at that edge; bytes with be[i]=0 unchanged.
  - be=0 is accepted and changes nothing.
  - No rvalid is produced for writes.
- Accepted read: word latched from the array at the acceptance edge.
  - READ_LATENCY=1: rdata/rvalid valid in the cycle after acceptance.
  - READ_LATENCY=2: one extra output register stage.
  - rvalid is a one-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.
- rdata holds its last value while rvalid=0. Only the accepting port's rdata/rvalid change.
- Read after write to the same address in any later cycle returns the new data. The same cycle is impossible by construction.
- Address wrap: none. Every address in 0..2**ADDR_WIDTH-1 is valid.
- Reset:
  - rvalid outputs, rdata outputs and the read pipeline clear to 0.
  - Arbitration state returns to "A preferred".
  - Array contents are NOT cleared.
  - Reads in flight when rst asserts are dropped; no rvalid for them after reset.
  - While rst=1, gnt=0 on both ports and no writes occur.

Optional Feature:
- Macro: MEMORY_ARB2_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - A one-bit last-winner register selects, on a tie, the port that did not win the most recent contested or uncontested grant.
  - Reset value: A preferred.
- Undefined: fixed priority; port A always wins a tie and port B waits (starvation permitted). No last-winner register is built.

Test Plan:
- Init/read: after reset, A reads addr 0x00 with file word 0x1234, READ_LATENCY=1 -> a_rvalid=1 with a_rdata=0x1234 exactly one cycle after acceptance; b_rvalid stays 0.
- Byte write: A writes addr 0x05 data 0xABCD be=2'b01 over 0x1234, then reads 0x05 -> 0x12CD. Then be=2'b10 data 0x5600 -> read returns 0x56CD.
- Contention, fixed priority: A and B both request for 3 cycles -> a_gnt=1 every cycle, b_gnt=0. B is granted in the first cycle A drops req.
- Contention, MEMORY_ARB2_ROUND_ROBIN_EN: A and B request continuously for 4 cycles -> grants alternate A, B, A, B; each port's rvalid pulses in order with the correct data.
- Latency 2: READ_LATENCY=2, B reads 0x3F (value 0xFFFF) then immediately 0x00 -> b_rvalid pulses in cycles +2 and +3 carrying 0xFFFF then 0x1234.
- Reset mid-read: A read accepted, rst=1 on the next edge -> a_rvalid never asserts, a_rdata=0. Previously written word at 0x05 is still 0x56CD after reset.
